// File: rtl/instr_encoder_pkg.sv
// Shared opcode header for the instruction encoder: RV32I opcode values,
// the ADDI func3, the all-zero error word and the encoder FSM states.
package instr_encoder_pkg;

    localparam logic [6:0] OPC_I   = 7'b0010011;
    localparam logic [6:0] OPC_LD  = 7'b0000011;
    localparam logic [6:0] OPC_S   = 7'b0100011;
    localparam logic [6:0] OPC_B   = 7'b1100011;
    localparam logic [6:0] OPC_J   = 7'b1101111;
    localparam logic [6:0] OPC_JR  = 7'b1100111;
    localparam logic [6:0] OPC_U   = 7'b0110111;
    localparam logic [6:0] OPC_UPC = 7'b0010111;
    localparam logic [6:0] OPC_R   = 7'b0110011;

    localparam logic [2:0] F3_ADDI = 3'b000;

    // Error beats carry an all-zero word, which is never a legal (or NOP) instruction.
    localparam logic [31:0] ERR_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT1 = 2'd1,
        ST_OUT2 = 2'd2
    } state_t;

    // True when v is a sign-extended nbits-wide value (all bits above nbits-1 match the sign).
    function automatic logic fits_signed(input logic [31:0] v, input int unsigned nbits);
        logic [31:0] m;
        m = 32'hFFFF_FFFF << (nbits - 1);
        return ((v & m) == m) || ((v & m) == 32'h0);
    endfunction

endpackage

// File: rtl/instr_encoder_pack.sv
// instr_pack: combinational field placement and range/alignment checking for
// one decoded RV32I request. With ENC_LI_EXPAND_EN defined it also computes
// the LUI/ADDI split for out-of-range load-immediate requests.
module instr_pack
    import instr_encoder_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  func3,
    input  logic [6:0]  func7,
    input  logic [31:0] imm,
    output logic [31:0] instr0,
    output logic [31:0] instr1,
    output logic        expand,
    output logic        err
);

    logic imm12_ok;
    assign imm12_ok = fits_signed(imm, 12);

`ifdef ENC_LI_EXPAND_EN
    // Rounded upper part: ADDI sign-extends its low 12 bits, so LUI must carry the borrow.
    logic [31:0] imm_rnd;
    assign imm_rnd = imm + 32'h0000_0800;
`endif

    // Place fields per base format and flag illegal immediates / opcodes.
    always_comb begin
        instr0 = ERR_INSTR;
        instr1 = ERR_INSTR;
        expand = 1'b0;
        err    = 1'b0;
        case (opcode)
            OPC_I, OPC_LD, OPC_JR: begin
                instr0 = {imm[11:0], rs1, func3, rd, opcode};
                err    = !imm12_ok;
            end
            OPC_S: begin
                instr0 = {imm[11:5], rs2, rs1, func3, imm[4:0], opcode};
                err    = !imm12_ok;
            end
            OPC_B: begin
                instr0 = {imm[12], imm[10:5], rs2, rs1, func3, imm[4:1], imm[11], opcode};
                err    = !fits_signed(imm, 13) || imm[0];
            end
            OPC_J: begin
                instr0 = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                err    = !fits_signed(imm, 21) || imm[0];
            end
            OPC_U, OPC_UPC: begin
                instr0 = {imm[31:12], rd, opcode};
                err    = |imm[11:0];
            end
            OPC_R: begin
                instr0 = {func7, rs2, rs1, func3, rd, opcode};
            end
            default: begin
                err = 1'b1;
            end
        endcase
`ifdef ENC_LI_EXPAND_EN
        // Load-immediate that does not fit 12 bits: LUI first, ADDI only if low bits are nonzero.
        if (opcode == OPC_I && func3 == F3_ADDI && rs1 == 5'd0 && !imm12_ok) begin
            err    = 1'b0;
            instr0 = {imm_rnd[31:12], rd, OPC_U};
            instr1 = {imm[11:0], rd, F3_ADDI, rd, OPC_I};
            expand = |imm[11:0];
        end
`endif
        if (err) begin
            instr0 = ERR_INSTR;
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: valid/ready wrapper around instr_pack. Owns the output beat
// registers and the IDLE/OUT1/OUT2 FSM. Optional ENC_LI_EXPAND_EN enables
// the two-beat LUI+ADDI expansion (OUT2 and the held second word).
module instr_encoder
    import instr_encoder_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [6:0]  i_opcode,
    input  logic [4:0]  i_rd,
    input  logic [4:0]  i_rs1,
    input  logic [4:0]  i_rs2,
    input  logic [2:0]  i_func3,
    input  logic [6:0]  i_func7,
    input  logic [31:0] i_imm,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic        o_err,
    output logic        o_last
);

    logic [31:0] p_instr0, p_instr1;
    logic        p_expand, p_err;

    instr_pack u_pack (
        .opcode (i_opcode),
        .rd     (i_rd),
        .rs1    (i_rs1),
        .rs2    (i_rs2),
        .func3  (i_func3),
        .func7  (i_func7),
        .imm    (i_imm),
        .instr0 (p_instr0),
        .instr1 (p_instr1),
        .expand (p_expand),
        .err    (p_err)
    );

    state_t      state_q, state_d;
    logic [31:0] instr_q, instr_d;
    logic        err_q, err_d;
    logic        last_q, last_d;
`ifdef ENC_LI_EXPAND_EN
    logic [31:0] pend_q, pend_d;
`else
    logic        unused_pack;
    assign unused_pack = ^p_instr1;
`endif

    logic accept, hs;

    assign o_valid = (state_q != ST_IDLE);
    assign o_instr = instr_q;
    assign o_err   = err_q;
    assign o_last  = last_q;
    // A new request may load only when the final beat of the current one leaves.
    assign o_ready = (state_q == ST_IDLE) || (last_q && i_ready);
    assign accept  = i_valid && o_ready;
    assign hs      = o_valid && i_ready;

    // Next-state and next-beat selection; outputs hold unless a beat is consumed.
    always_comb begin
        state_d = state_q;
        instr_d = instr_q;
        err_d   = err_q;
        last_d  = last_q;
`ifdef ENC_LI_EXPAND_EN
        pend_d  = pend_q;
`endif
        if (state_q == ST_IDLE || hs) begin
            if (accept) begin
                state_d = ST_OUT1;
                instr_d = p_instr0;
                err_d   = p_err;
                last_d  = p_err || !p_expand;
`ifdef ENC_LI_EXPAND_EN
                pend_d  = p_instr1;
`endif
            end
`ifdef ENC_LI_EXPAND_EN
            else if (state_q == ST_OUT1 && !last_q) begin
                state_d = ST_OUT2;
                instr_d = pend_q;
                err_d   = 1'b0;
                last_d  = 1'b1;
            end
`endif
            else begin
                state_d = ST_IDLE;
                instr_d = ERR_INSTR;
                err_d   = 1'b0;
                last_d  = 1'b0;
            end
        end
    end

    // State and output registers; reset drops any pending beat and same-cycle request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            instr_q <= ERR_INSTR;
            err_q   <= 1'b0;
            last_q  <= 1'b0;
`ifdef ENC_LI_EXPAND_EN
            pend_q  <= ERR_INSTR;
`endif
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            last_q  <= last_d;
`ifdef ENC_LI_EXPAND_EN
            pend_q  <= pend_d;
`endif
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: vector table, scoreboard monitor,
// hand sequences for backpressure, expansion and reset, random round-trip.
module tb_instr_encoder;
    import instr_encoder_pkg::*;

    logic        i_clk = 1'b0;
    logic        i_rst, i_valid, o_ready, o_valid, i_ready, o_err, o_last;
    logic [6:0]  i_opcode, i_func7;
    logic [4:0]  i_rd, i_rs1, i_rs2;
    logic [2:0]  i_func3;
    logic [31:0] i_imm, o_instr;

    always #5 i_clk = ~i_clk;

    instr_encoder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_opcode(i_opcode), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
        .i_func3(i_func3), .i_func7(i_func7), .i_imm(i_imm),
        .o_valid(o_valid), .i_ready(i_ready), .o_instr(o_instr),
        .o_err(o_err), .o_last(o_last)
    );

    typedef struct {
        logic [6:0] op; logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2;
        logic [2:0] f3; logic [6:0] f7; logic [31:0] imm;
        logic [31:0] instr; logic err;
    } vec_t;

    typedef struct {
        logic [31:0] instr; logic err; logic last;
        bit rt; logic [6:0] op; logic [31:0] imm;
    } exp_t;

    exp_t sb[$];
    exp_t cur0, cur1, mon_e;
    int   cur_n = 1;
    int   nchk = 0, nerr = 0, stalls = 0;
    vec_t tbl[21];

    function automatic vec_t mkv(logic [6:0] op, logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2,
                                 logic [2:0] f3, logic [6:0] f7, logic [31:0] imm,
                                 logic [31:0] instr, logic err);
        vec_t v;
        v.op = op; v.rd = rd; v.rs1 = rs1; v.rs2 = rs2; v.f3 = f3; v.f7 = f7;
        v.imm = imm; v.instr = instr; v.err = err;
        return v;
    endfunction

    function automatic exp_t mke(logic [31:0] instr, logic err, logic last);
        exp_t e;
        e.instr = instr; e.err = err; e.last = last; e.rt = 1'b0; e.op = 7'd0; e.imm = 32'd0;
        return e;
    endfunction

    // Immediate recovery as the core's immediate generator does it.
    function automatic logic [31:0] dec_imm(logic [6:0] op, logic [31:0] w);
        case (op)
            OPC_S:          return {{20{w[31]}}, w[31:25], w[11:7]};
            OPC_B:          return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
            OPC_J:          return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
            OPC_U, OPC_UPC: return {w[31:12], 12'h000};
            default:        return {{20{w[31]}}, w[31:20]};
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Scoreboard: pop on each consumed beat, push on each accepted request.
    always @(negedge i_clk) begin
        if (i_rst) begin
            sb.delete();
        end else begin
            if (o_valid && i_ready) begin
                nchk++;
                if (sb.size() == 0) begin
                    nerr++;
                    $display("FAIL beat_unexpected: got instr=%h err=%b last=%b, expected no beat",
                             o_instr, o_err, o_last);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.rt) begin
                        if (o_err !== 1'b0 || o_last !== 1'b1 || o_instr[6:0] !== mon_e.op ||
                            dec_imm(mon_e.op, o_instr) !== mon_e.imm) begin
                            nerr++;
                            $display("FAIL roundtrip: got instr=%h imm=%h err=%b, expected op=%b imm=%h",
                                     o_instr, dec_imm(mon_e.op, o_instr), o_err, mon_e.op, mon_e.imm);
                        end
                    end else if (o_instr !== mon_e.instr || o_err !== mon_e.err || o_last !== mon_e.last) begin
                        nerr++;
                        $display("FAIL beat: got instr=%h err=%b last=%b, expected instr=%h err=%b last=%b",
                                 o_instr, o_err, o_last, mon_e.instr, mon_e.err, mon_e.last);
                    end
                end
            end
            if (i_valid && o_ready) begin
                sb.push_back(cur0);
                if (cur_n == 2) sb.push_back(cur1);
            end
        end
    end

    task automatic drive(vec_t v);
        i_opcode = v.op; i_rd = v.rd; i_rs1 = v.rs1; i_rs2 = v.rs2;
        i_func3 = v.f3; i_func7 = v.f7; i_imm = v.imm;
    endtask

    // Hold i_valid until accepted; a stall raises i_ready so the beat drains.
    task automatic send_raw();
        int  n;
        bit  acc;
        n = 0;
        i_valid = 1'b1;
        forever begin
            @(negedge i_clk);
            acc = o_ready;
            @(posedge i_clk);
            #1;
            if (acc) break;
            stalls++;
            i_ready = 1'b1;
            n++;
            if (n >= 50) begin
                nchk++; nerr++;
                $display("FAIL accept_timeout: got no accept in 50 cycles, expected accept");
                break;
            end
        end
        i_valid = 1'b0;
    endtask

    task automatic send_v(vec_t v);
        drive(v);
        cur_n = 1;
        cur0  = mke(v.instr, v.err, 1'b1);
        send_raw();
    endtask

    task automatic send_li(logic [4:0] rd, logic [31:0] imm, logic [31:0] w0, logic [31:0] w1, bit two);
        drive(mkv(OPC_I, rd, 5'd0, 5'd0, F3_ADDI, 7'd0, imm, 32'd0, 1'b0));
`ifdef ENC_LI_EXPAND_EN
        cur_n = two ? 2 : 1;
        cur0  = mke(w0, 1'b0, !two);
        cur1  = mke(w1, 1'b0, 1'b1);
`else
        cur_n = 1;
        cur0  = mke(32'd0, 1'b1, 1'b1);
        cur1  = mke(w1 & 32'd0, 1'b0, two);
        if (w0 == 32'hFFFF_FFFF) cur1.err = 1'b1;
`endif
        send_raw();
    endtask

    task automatic idle(int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    logic [6:0]  ops [8];
    logic [31:0] r;
    vec_t        rv;

    initial begin
        tbl[0]  = mkv(OPC_I,   5'd5,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFF, 32'hFFF0_0293, 1'b0);
        tbl[1]  = mkv(OPC_S,   5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'h0000_0008, 32'h0020_A423, 1'b0);
        tbl[2]  = mkv(OPC_J,   5'd0,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_FFFC, 32'hFFDF_F06F, 1'b0);
        tbl[3]  = mkv(OPC_B,   5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0003, 32'h0000_0000, 1'b1);
        tbl[4]  = mkv(OPC_U,   5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0000_1001, 32'h0000_0000, 1'b1);
        tbl[5]  = mkv(OPC_R,   5'd3,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0000, 32'h0020_81B3, 1'b0);
        tbl[6]  = mkv(OPC_R,   5'd3,  5'd1, 5'd2, 3'd0, 7'h20, 32'h0000_0000, 32'h4020_81B3, 1'b0);
        tbl[7]  = mkv(OPC_U,   5'd10, 5'd0, 5'd0, 3'd0, 7'h00, 32'h1234_5000, 32'h1234_5537, 1'b0);
        tbl[8]  = mkv(OPC_I,   5'd1,  5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_07FF, 32'h7FF1_0093, 1'b0);
        tbl[9]  = mkv(OPC_I,   5'd1,  5'd2, 5'd0, 3'd0, 7'h00, 32'h0000_0800, 32'h0000_0000, 1'b1);
        tbl[10] = mkv(OPC_I,   5'd1,  5'd2, 5'd0, 3'd0, 7'h00, 32'hFFFF_F800, 32'h8001_0093, 1'b0);
        tbl[11] = mkv(OPC_B,   5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_0FFE, 32'h7E20_8FE3, 1'b0);
        tbl[12] = mkv(OPC_B,   5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'h0000_1000, 32'h0000_0000, 1'b1);
        tbl[13] = mkv(OPC_B,   5'd0,  5'd1, 5'd2, 3'd0, 7'h00, 32'hFFFF_F000, 32'h8020_8063, 1'b0);
        tbl[14] = mkv(OPC_J,   5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h0010_0000, 32'h0000_0000, 1'b1);
        tbl[15] = mkv(OPC_J,   5'd1,  5'd0, 5'd0, 3'd0, 7'h00, 32'h000F_FFFE, 32'h7FFF_F0EF, 1'b0);
        tbl[16] = mkv(7'h7F,   5'd1,  5'd1, 5'd1, 3'd0, 7'h00, 32'h0000_0000, 32'h0000_0000, 1'b1);
        tbl[17] = mkv(OPC_LD,  5'd5,  5'd6, 5'd0, 3'd2, 7'h00, 32'hFFFF_FFFC, 32'hFFC3_2283, 1'b0);
        tbl[18] = mkv(OPC_JR,  5'd1,  5'd5, 5'd0, 3'd0, 7'h00, 32'h0000_0000, 32'h0002_80E7, 1'b0);
        tbl[19] = mkv(OPC_UPC, 5'd2,  5'd0, 5'd0, 3'd0, 7'h00, 32'hFFFF_F000, 32'hFFFF_F117, 1'b0);
        tbl[20] = mkv(OPC_S,   5'd0,  5'd1, 5'd2, 3'd2, 7'h00, 32'hFFFF_F7FF, 32'h0000_0000, 1'b1);
        ops = '{OPC_I, OPC_LD, OPC_S, OPC_B, OPC_J, OPC_JR, OPC_U, OPC_UPC};

        // Reset state
        i_rst = 1'b1; i_valid = 1'b0; i_ready = 1'b1;
        drive(tbl[0]);
        cur0 = mke(32'd0, 1'b0, 1'b1); cur1 = cur0;
        idle(3);
        i_rst = 1'b0;
        chk("rst_valid", {31'd0, o_valid}, 32'd0);
        chk("rst_instr", o_instr, 32'd0);
        chk("rst_err",   {31'd0, o_err}, 32'd0);
        chk("rst_last",  {31'd0, o_last}, 32'd0);
        chk("rst_ready", {31'd0, o_ready}, 32'd1);

        // One-cycle latency: beat registered right after the accept edge
        send_v(tbl[0]);
        chk("lat_valid", {31'd0, o_valid}, 32'd1);
        chk("lat_instr", o_instr, 32'hFFF0_0293);
        idle(2);

        // Vector table streamed back to back
        stalls = 0;
        for (int i = 0; i < 21; i++) send_v(tbl[i]);
        chk("table_no_bubble", stalls, 32'd0);
        idle(2);

        // Backpressure: beat held stable, no accept while blocked
        i_ready = 1'b0;
        send_v(tbl[1]);
        drive(tbl[5]); cur_n = 1; cur0 = mke(tbl[5].instr, 1'b0, 1'b1);
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("bp_instr", o_instr, 32'h0020_A423);
            chk("bp_ready", {31'd0, o_ready}, 32'd0);
        end
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        stalls = 0;
        send_v(tbl[5]); send_v(tbl[6]); send_v(tbl[7]);
        chk("bp_release_no_bubble", stalls, 32'd0);
        idle(2);

        // Load-immediate expansion (or single error beat without the option)
        send_li(5'd1, 32'h1234_5FFF, 32'h1234_60B7, 32'hFFF0_8093, 1'b1);
        @(negedge i_clk);
`ifdef ENC_LI_EXPAND_EN
        chk("li_beat1", o_instr, 32'h1234_60B7);
        chk("li_beat1_last", {31'd0, o_last}, 32'd0);
        chk("li_beat1_ready", {31'd0, o_ready}, 32'd0);
`else
        chk("li_err", {31'd0, o_err}, 32'd1);
        chk("li_err_instr", o_instr, 32'd0);
`endif
        send_v(tbl[7]);
        send_li(5'd3, 32'h1234_5000, 32'h1234_51B7, 32'd0, 1'b0);
        idle(3);

        // Reset while the first expansion beat is held; same-cycle request dropped
        i_ready = 1'b0;
        send_li(5'd1, 32'h1234_5FFF, 32'h1234_60B7, 32'hFFF0_8093, 1'b1);
        @(negedge i_clk);
        chk("mid_valid", {31'd0, o_valid}, 32'd1);
        @(posedge i_clk); #1;
        i_rst = 1'b1;
        drive(tbl[5]); i_valid = 1'b1;
        @(posedge i_clk); #1;
        i_rst = 1'b0; i_valid = 1'b0;
        chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, o_ready}, 32'd1);
        chk("mid_rst_instr", o_instr, 32'd0);
        i_ready = 1'b1;
        idle(5);

        // Random legal round-trip
        for (int i = 0; i < 40; i++) begin
            r = $urandom;
            rv = mkv(ops[$urandom_range(0, 7)], 5'($urandom), 5'($urandom), 5'($urandom),
                     3'($urandom), 7'd0, 32'd0, 32'd0, 1'b0);
            case (rv.op)
                OPC_B:          rv.imm = {{19{r[12]}}, r[12:1], 1'b0};
                OPC_J:          rv.imm = {{11{r[20]}}, r[20:1], 1'b0};
                OPC_U, OPC_UPC: rv.imm = {r[19:0], 12'h000};
                default:        rv.imm = {{20{r[11]}}, r[11:0]};
            endcase
            drive(rv);
            cur_n = 1;
            cur0 = mke(32'd0, 1'b0, 1'b1);
            cur0.rt = 1'b1; cur0.op = rv.op; cur0.imm = rv.imm;
            i_ready = ($urandom_range(0, 3) != 0);
            send_raw();
        end
        i_ready = 1'b1;
        idle(4);
        chk("sb_drain", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Packs decoded RV32I instruction fields (opcode, registers, func3/func7, full 32-bit immediate value) into a 32-bit instruction word. It is the inverse of the core's immediate generator: for every legal input, decoding the emitted word returns the supplied `i_imm` exactly. The block sits in the self-test / boot-stub generator path, between the sequence controller and the instruction-memory writer, and uses a valid/ready handshake on both sides. An optional mode expands out-of-range `ADDI rd, x0, imm` (load-immediate) into a `LUI` + `ADDI` pair.

## Interface
- No parameters; opcode values come from the shared opcode header.
- `i_clk` in 1: clock, rising edge.
- `i_rst` in 1: synchronous, active-high reset.
- `i_valid` in 1: input request valid.
- `o_ready` out 1: block can accept a request this cycle.
- `i_opcode` in 7: one of `I`, `LD`, `S`, `B`, `J`, `JR`, `U`, `UPC`, `R`.
- `i_rd`, `i_rs1`, `i_rs2` in 5 each: register indices.
- `i_func3` in 3, `i_func7` in 7: function fields (`i_func7` used by `R` only).
- `i_imm` in 32: immediate as a full sign-extended value (`U`/`UPC`: already shifted left by 12).
- `o_valid` out 1: output beat valid.
- `i_ready` in 1: downstream accepts the beat.
- `o_instr` out 32: encoded instruction.
- `o_err` out 1: the beat is an error marker; `o_instr` = 0.
- `o_last` out 1: final beat of the current request.

## Operation
- Range/alignment rules (violation → one error beat):
  - `I`/`LD`/`S`/`JR`: imm in [-2048, 2047].
  - `B`: imm in [-4096, 4094] and imm[0] = 0.
  - `J`: imm in [-2^20, 2^20-2] and imm[0] = 0.
  - `U`/`UPC`: imm[11:0] = 0.
  - `R`: imm ignored.
  - Unknown opcode: error.
- Field placement follows the RV32I base formats; the sign bit always goes to instr[31].
- FSM states:
  - `IDLE`: `o_valid` = 0.
  - `OUT1`: beat 1 held.
  - `OUT2`: beat 2 of an expansion held.
- FSM transitions:
  - `IDLE` → `OUT1` on accept.
  - `OUT1` → `OUT2` on beat-1 handshake when the request expands.
  - `OUT1` → `OUT1` on handshake with a simultaneous new accept.
  - Otherwise `OUT1` → `IDLE` on handshake.
  - `OUT2` → `IDLE` or `OUT1` on handshake, with the same rule as `OUT1`.
- `o_ready` = (state == `IDLE`) or (`o_last` and `i_ready`).
- No other bubbles for single-beat requests.
- Error beats: `o_err` = 1, `o_last` = 1, `o_instr` = 0, single beat.

## Timing
- Latency: accept at cycle N → beat valid at cycle N+1, registered.
- Throughput: 1 request/cycle for single-beat requests; 2 cycles for an expansion with `i_ready` held high.
- While `o_valid`=1 and `i_ready`=0, `o_instr`, `o_err` and `o_last` are held stable.
- Reset values: `o_valid`=0, `o_instr`=0, `o_err`=0, `o_last`=0, state `IDLE`; `o_ready`=1 in the first cycle after reset.
- Reset mid-expansion discards the pending second beat. A request accepted in the same cycle as `i_rst` is dropped.

## Configuration
- `ENC_LI_EXPAND_EN` defined: an expansion triggers for `i_opcode`=`I`, `i_func3`=000, `i_rs1`=0, with imm outside the 12-bit range.
  - Beat 1: `LUI rd, hi` with hi = (imm + 0x800) >> 12, truncated to 20 bits; `o_last`=0.
  - Beat 2: `ADDI rd, rd, imm[11:0]`; `o_last`=1.
  - If imm[11:0] = 0, only the `LUI` beat is emitted, with `o_last`=1.
- Undefined: the same request produces an error beat. The `OUT2` state and the expansion logic are not synthesized.

## Structure
- Shared opcode header holds:
  - opcode macros, adding `R` = 0110011;
  - `F3_ADDI` = 3'b000;
  - the NOP-free error-code convention (`o_instr` = 0).
- Sub-module `instr_pack`, purely combinational, does:
  - range/alignment check;
  - field placement;
  - LUI/ADDI split computation.
  - It outputs the `instr0`, `instr1`, `expand` and `err` signals.
- `instr_encoder` owns the FSM, output registers and handshake.

## Test plan
- `ADDI x5, x0, -1` (op `I`, rd=5, imm=0xFFFFFFFF) → next cycle `o_instr`=0xFFF00293, `o_last`=1, `o_err`=0.
- `SW x2, 8(x1)` (op `S`, rs1=1, rs2=2, func3=010, imm=8) → `o_instr`=0x0020A423. `JAL x0, -4` → 0xFFDFF06F.
- op `B`, imm=3 → one beat with `o_err`=1, `o_instr`=0. op `U`, imm=0x00001001 → `o_err`=1.
- With `ENC_LI_EXPAND_EN`: `ADDI x1, x0, 0x12345FFF` → beats 0x123460B7 (`o_last`=0), then 0xFFF08093 (`o_last`=1). Without the macro → a single error beat.
- Backpressure: `i_ready` held low for 3 cycles during a beat → `o_instr` stable and `o_ready`=0; on release, back-to-back requests are accepted every cycle.
- Reset during `OUT1` of an expansion → next cycle `o_valid`=0, no `ADDI` beat is emitted, and `o_ready`=1.
- Random round-trip: legal random fields → decoding the immediate of `o_instr` equals `i_imm`.
